// File: rtl/fb_pkg.sv
// Shared constants and helpers for the OLED framebuffer write path.
// Geometry is fixed to the 96x64 RGB565 panel.
package fb_pkg;

    localparam int SCR_W    = 96;
    localparam int SCR_H    = 64;
    localparam int COL_W    = 16;
    localparam int ADDR_W   = 13;
    localparam int X_W      = 7;
    localparam int Y_W      = 6;
    localparam int FB_DEPTH = SCR_W * SCR_H;

    function automatic logic in_bounds(
        input logic [X_W-1:0] x,
        input logic [Y_W-1:0] y
    );
        return (8'(x) < 8'(SCR_W)) && (8'(y) < 8'(SCR_H));
    endfunction

    // y*96 + x built from shifts so no multiplier is inferred
    function automatic logic [ADDR_W-1:0] pix_index(
        input logic [X_W-1:0] x,
        input logic [Y_W-1:0] y
    );
        logic [ADDR_W-1:0] yw;
        yw = ADDR_W'(y);
        return (yw << 6) + (yw << 5) + ADDR_W'(x);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after
// the pointer, searching cyclically. The pointer register lives outside.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             en,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    int c;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        c     = 0;
        if (en) begin
            for (int k = 0; k < N_REQ; k++) begin
                c = int'(ptr) + k;
                if (c >= N_REQ) begin
                    c = c - N_REQ;
                end
                if (!valid && req[IDX_W'(c)]) begin
                    valid            = 1'b1;
                    gnt[IDX_W'(c)]   = 1'b1;
                    idx              = IDX_W'(c);
                end
            end
        end
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// Round-robin arbiter sharing the framebuffer write port among N drawers.
// Define FB_WRITE_ARB_STRICT0_EN to give requester 0 strict priority.
module fb_write_arbiter
    import fb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*X_W-1:0]   x_in,
    input  logic [N_REQ*Y_W-1:0]   y_in,
    input  logic [N_REQ*COL_W-1:0] col_in,
    output logic [N_REQ-1:0]       grant,
    output logic                   fb_we,
    output logic [ADDR_W-1:0]      fb_addr,
    output logic [COL_W-1:0]       fb_data,
    input  logic                   fb_ready,
    output logic [7:0]             oob_cnt
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic              fb_we_q, fb_we_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [COL_W-1:0]  fb_data_q, fb_data_d;
    logic [7:0]        oob_cnt_q, oob_cnt_d;

    logic              slot_free;
    logic              arb_en;
    logic              rr_en;
    logic [N_REQ-1:0]  arb_req;
    logic [N_REQ-1:0]  rr_gnt;
    logic [IDX_W-1:0]  rr_idx;
    logic              rr_any;
    logic [IDX_W-1:0]  win_idx;
    logic              adv;
    logic              any_gnt;
    logic [X_W-1:0]    x_sel;
    logic [Y_W-1:0]    y_sel;
    logic [COL_W-1:0]  col_sel;
    logic              inb;

    // Slot drains this cycle if it is empty or the RAM takes the write now
    assign slot_free = !fb_we_q || fb_ready;
    assign arb_en    = slot_free && !reset;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req   (arb_req),
        .ptr   (ptr_q),
        .en    (rr_en),
        .gnt   (rr_gnt),
        .idx   (rr_idx),
        .valid (rr_any)
    );

`ifdef FB_WRITE_ARB_STRICT0_EN
    logic strict0;

    // Requester 0 is masked out of the ring; the ring pointer skips it
    assign strict0 = arb_en && req[0];
    assign arb_req = req & ~N_REQ'(1);
    assign rr_en   = arb_en && !req[0];
    assign grant   = strict0 ? N_REQ'(1) : rr_gnt;
    assign win_idx = strict0 ? '0 : rr_idx;
    assign adv     = rr_any && !strict0;
`else
    assign arb_req = req;
    assign rr_en   = arb_en;
    assign grant   = rr_gnt;
    assign win_idx = rr_idx;
    assign adv     = rr_any;
`endif

    assign any_gnt = |grant;

    always_comb begin
        x_sel   = '0;
        y_sel   = '0;
        col_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (IDX_W'(i) == win_idx) begin
                x_sel   = x_in[i*X_W +: X_W];
                y_sel   = y_in[i*Y_W +: Y_W];
                col_sel = col_in[i*COL_W +: COL_W];
            end
        end
    end

    assign inb = in_bounds(x_sel, y_sel);

    always_comb begin
        fb_we_d   = fb_we_q && !fb_ready;
        fb_addr_d = fb_addr_q;
        fb_data_d = fb_data_q;
        oob_cnt_d = oob_cnt_q;
        ptr_d     = ptr_q;
        if (any_gnt) begin
            fb_we_d = inb;
            if (inb) begin
                fb_addr_d = pix_index(x_sel, y_sel);
                fb_data_d = col_sel;
            end else if (oob_cnt_q != 8'hFF) begin
                oob_cnt_d = oob_cnt_q + 8'd1;
            end
        end
        if (adv) begin
            ptr_d = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q     <= '0;
            fb_we_q   <= 1'b0;
            fb_addr_q <= '0;
            fb_data_q <= '0;
            oob_cnt_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            fb_we_q   <= fb_we_d;
            fb_addr_q <= fb_addr_d;
            fb_data_q <= fb_data_d;
            oob_cnt_q <= oob_cnt_d;
        end
    end

    assign fb_we   = fb_we_q;
    assign fb_addr = fb_addr_q;
    assign fb_data = fb_data_q;
    assign oob_cnt = oob_cnt_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Scoreboard bench for fb_write_arbiter: expected writes queued at grant,
// popped when the framebuffer accepts a write.
module tb_fb_write_arbiter;

    typedef struct packed {
        logic [12:0] a;
        logic [15:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [27:0] x_in;
    logic [23:0] y_in;
    logic [63:0] col_in;
    logic [3:0]  grant;
    logic        fb_we;
    logic [12:0] fb_addr;
    logic [15:0] fb_data;
    logic        fb_ready;
    logic [7:0]  oob_cnt;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    fb_write_arbiter #(.N_REQ(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .x_in     (x_in),
        .y_in     (y_in),
        .col_in   (col_in),
        .grant    (grant),
        .fb_we    (fb_we),
        .fb_addr  (fb_addr),
        .fb_data  (fb_data),
        .fb_ready (fb_ready),
        .oob_cnt  (oob_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_rq(input int i, input int x, input int y,
                          input logic [15:0] c);
        x_in[i*7 +: 7]    = 7'(x);
        y_in[i*6 +: 6]    = 6'(y);
        col_in[i*16 +: 16] = c;
    endtask

    task automatic push(input int x, input int y, input logic [15:0] c);
        exp_t e;
        e.a = 13'(y * 96 + x);
        e.d = c;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        req      = '0;
        fb_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        step();
    endtask

    always @(negedge clk) begin
        if (!reset && fb_we === 1'b1 && fb_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_write", 32'(fb_addr), 32'h1FFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_addr", 32'(fb_addr), 32'(e.a));
                chk("sb_data", 32'(fb_data), 32'(e.d));
            end
        end
    end

    initial begin
        int cnt;
        reset    = 1'b1;
        req      = '0;
        x_in     = '0;
        y_in     = '0;
        col_in   = '0;
        fb_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", 32'(grant), 0);
        chk("rst_we", 32'(fb_we), 0);
        chk("rst_addr", 32'(fb_addr), 0);
        chk("rst_data", 32'(fb_data), 0);
        chk("rst_oob", 32'(oob_cnt), 0);
        @(negedge clk);
        reset = 1'b0;
        step();

        // single corner-pixel write
        set_rq(0, 95, 63, 16'hF800);
        req = 4'b0001;
        at_neg();
        chk("single_gnt", 32'(grant), 32'h1);
        push(95, 63, 16'hF800);
        step();
        req = 4'b0000;
        at_neg();
        chk("single_gnt_off", 32'(grant), 0);
        chk("single_we", 32'(fb_we), 1);
        chk("single_addr", 32'(fb_addr), 6143);
        chk("single_data", 32'(fb_data), 32'hF800);
        step();
        at_neg();
        chk("single_idle", 32'(fb_we), 0);
        step();

`ifdef FB_WRITE_ARB_STRICT0_EN
        do_reset();
        for (int i = 0; i < 4; i++) set_rq(i, 10*i + 1, i + 2, 16'h1000 + 16'(i));
        req = 4'b0111;
        for (int k = 0; k < 4; k++) begin
            at_neg();
            chk("strict_r0", 32'(grant), 32'h1);
            push(1, 2, 16'h1000);
            step();
        end
        req = 4'b0110;
        for (int k = 0; k < 4; k++) begin
            at_neg();
            chk("strict_alt", 32'(grant), (k % 2 == 0) ? 32'h2 : 32'h4);
            push(10*(1 + k%2) + 1, 3 + k%2, 16'h1001 + 16'(k%2));
            step();
        end
        req = 4'b0000;
        at_neg();
        step();
        at_neg();
        chk("strict_drain", sb.size(), 0);
        step();
`else
        do_reset();
        for (int i = 0; i < 4; i++) set_rq(i, 10*i + 1, i + 2, 16'h1000 + 16'(i));
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            at_neg();
            chk("fair_gnt", 32'(grant), 32'(1 << (k % 4)));
            push(10*(k%4) + 1, k%4 + 2, 16'h1000 + 16'(k%4));
            step();
        end
        req = 4'b0000;
        at_neg();
        step();
        at_neg();
        chk("fair_drain", sb.size(), 0);
        step();
`endif

        // backpressure holds the slot and blocks grants
        do_reset();
        set_rq(0, 5, 1, 16'hAAAA);
        req = 4'b0001;
        at_neg();
        chk("bp_first_gnt", 32'(grant), 32'h1);
        push(5, 1, 16'hAAAA);
        step();
        set_rq(1, 7, 2, 16'hBBBB);
        req      = 4'b0010;
        fb_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            at_neg();
            chk("bp_gnt", 32'(grant), 0);
            chk("bp_we", 32'(fb_we), 1);
            chk("bp_addr", 32'(fb_addr), 101);
            chk("bp_data", 32'(fb_data), 32'hAAAA);
            step();
        end
        fb_ready = 1'b1;
        at_neg();
        chk("bp_resume_gnt", 32'(grant), 32'h2);
        push(7, 2, 16'hBBBB);
        step();
        req = 4'b0000;
        at_neg();
        chk("bp_nobubble_we", 32'(fb_we), 1);
        chk("bp_nobubble_addr", 32'(fb_addr), 199);
        step();
        at_neg();
        chk("bp_idle", 32'(fb_we), 0);
        step();

        // out-of-range requests are consumed but never written
        do_reset();
        set_rq(2, 96, 10, 16'h1234);
        req = 4'b0100;
        at_neg();
        chk("oob_gnt", 32'(grant), 32'h4);
        step();
        req = 4'b0000;
        at_neg();
        chk("oob_we", 32'(fb_we), 0);
        chk("oob_one", 32'(oob_cnt), 1);
        step();
        req = 4'b0100;
        cnt = 0;
        for (int k = 0; k < 300; k++) begin
            at_neg();
            if (grant == 4'b0100) cnt++;
            step();
        end
        req = 4'b0000;
        at_neg();
        chk("oob_grants", cnt, 300);
        chk("oob_sat", 32'(oob_cnt), 255);
        chk("oob_we_after", 32'(fb_we), 0);
        step();

        // asynchronous reset in the middle of a stalled write
        do_reset();
        set_rq(2, 96, 0, 16'h0000);
        req = 4'b0100;
        at_neg();
        chk("mr_oob_gnt", 32'(grant), 32'h4);
        step();
        set_rq(0, 1, 1, 16'hCAFE);
        req = 4'b0001;
        at_neg();
        chk("mr_load_gnt", 32'(grant), 32'h1);
        step();
        req      = 4'b0000;
        fb_ready = 1'b0;
        at_neg();
        chk("mr_stalled_we", 32'(fb_we), 1);
        chk("mr_oob_pre", 32'(oob_cnt), 1);
        #1;
        set_rq(0, 2, 2, 16'hBEEF);
        set_rq(3, 50, 40, 16'h07E0);
        req   = 4'b1001;
        reset = 1'b1;
        #1;
        chk("mr_we", 32'(fb_we), 0);
        chk("mr_grant", 32'(grant), 0);
        chk("mr_oob", 32'(oob_cnt), 0);
        chk("mr_addr", 32'(fb_addr), 0);
        @(posedge clk);
        @(negedge clk);
        fb_ready = 1'b1;
        reset    = 1'b0;
        #1;
        chk("mr_ptr0_gnt", 32'(grant), 32'h1);
        push(2, 2, 16'hBEEF);
        step();
        req = 4'b1000;
        at_neg();
        chk("mr_r3_gnt", 32'(grant), 32'h8);
        push(50, 40, 16'h07E0);
        step();
        req = 4'b0000;
        at_neg();
        step();
        at_neg();
        chk("mr_drain", sb.size(), 0);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fb_write_arbiter.md
Name: fb_write_arbiter

Overview:
- Shares the single write port of the 96x64 OLED framebuffer RAM between N drawing requesters (game logic, cursor, text overlay, and so on).
- Each requester presents an (x, y, colour) pixel write under a req/grant handshake.
- The block arbitrates round-robin, converts (x, y) to the linear pixel index y*96+x, and drives a registered write toward the framebuffer, honouring backpressure.
- It sits between the drawing engines and the framebuffer RAM, which the OLED scan side reads by pixel_index.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- SCR_W, 96, screen width in pixels.
- SCR_H, 64, screen height in pixels.
- COL_W, 16, colour width (RGB565).
- ADDR_W, 13, framebuffer address width.

Ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  asynchronous, active-high reset.
- req  in  N_REQ  per-requester write request; held until granted.
- x_in  in  N_REQ*7  packed x coordinates; requester i uses bits [7i+6:7i].
- y_in  in  N_REQ*6  packed y coordinates; requester i uses bits [6i+5:6i].
- col_in  in  N_REQ*COL_W  packed colours.
- grant  out  N_REQ  one-hot, one-cycle acknowledge; the request is consumed on this cycle.
- fb_we  out  1  write valid toward the framebuffer.
- fb_addr  out  ADDR_W  pixel index, y*SCR_W+x.
- fb_data  out  COL_W  pixel colour.
- fb_ready  in  1  framebuffer accepts the write when fb_we && fb_ready.
- oob_cnt  out  8  saturating count of dropped out-of-range requests.

Behaviour:
- Reset values: grant=0, fb_we=0, fb_addr=0, fb_data=0, oob_cnt=0, round-robin pointer=0. Reset is asynchronous and takes effect mid-transaction; any pending write is discarded without being replayed.
- Output slot: a single register stage (fb_we/fb_addr/fb_data). The slot is free when fb_we==0, or when fb_we && fb_ready in the current cycle.
- Arbitration:
  - Evaluated every cycle the slot is free and at least one req is high.
  - The winner is the first asserted req at or after the pointer, searching cyclically.
  - Exactly one grant bit pulses in that cycle.
  - The pointer becomes winner+1 mod N_REQ on the next edge.
  - No grant is issued while the slot is occupied and fb_ready=0.
- Latency and throughput:
  - The grant cycle's data is loaded into the slot at the same edge, so fb_we is visible one cycle after the grant.
  - Sustained throughput is one write per cycle while fb_ready=1.
- Hold rule:
  - A requester keeps req and its data stable until it sees grant.
  - It may deassert req without a grant; there is no penalty.
  - The block never grants a requester whose req is low.
- Address arithmetic:
  - fb_addr = (y<<6)+(y<<5)+x, computed at full 13-bit width.
  - The maximum valid value is 6143.
- Out-of-range requests (x>=SCR_W or y>=SCR_H):
  - The request is still granted, which consumes it.
  - It is not loaded, so fb_we stays 0 for that slot.
  - oob_cnt increments and saturates at 255.
  - The pointer advances as normal.
- Backpressure: while fb_we=1 and fb_ready=0, fb_we/fb_addr/fb_data hold stable.
- Simultaneous events: when the slot drains and a new grant occurs in the same cycle, the slot reloads with no bubble.
- All outputs are registered; there is no combinational path from fb_ready to fb_we.

Optional Feature:
- Macro: FB_WRITE_ARB_STRICT0_EN.
- Defined: requester 0 has strict priority. Whenever req[0]=1 and the slot is free, requester 0 wins. Requesters 1..N_REQ-1 round-robin among themselves with their own pointer, and the pointer does not advance on a requester-0 grant.
- Undefined: pure round-robin over all N_REQ requesters, exactly as described in Behaviour.

Decomposition:
- Package fb_pkg holds SCR_W, SCR_H, ADDR_W, COL_W, the derived FB_DEPTH=6144, and an in_bounds check on coordinates (x < SCR_W and y < SCR_H).
- One sub-module, rr_arbiter:
  - Parameterised by N_REQ.
  - Inputs: req, pointer, enable.
  - Output: one-hot grant plus the encoded winner index.
  - Purely combinational; the pointer register lives in fb_write_arbiter.

Test Plan:
- Single request: req=4'b0001, x=95, y=63, col=16'hF800, fb_ready=1 → grant[0] for one cycle; next cycle fb_we=1, fb_addr=6143, fb_data=F800.
- Fairness: req=4'b1111 held, fb_ready=1 → grants in order 0,1,2,3,0; each requester receives 1 grant in every 4 cycles.
- Backpressure: one write in the slot, fb_ready=0 for 5 cycles with req=4'b0010 → no grant, fb_addr/fb_data stable; fb_ready=1 → grant[1] that same cycle and the next write with no bubble.
- Out of range: req[2] with x=96, y=10 → grant[2] pulses, fb_we stays 0, oob_cnt 0→1; 300 such requests → oob_cnt=255.
- Reset mid-operation: assert reset while fb_we=1 and fb_ready=0 → fb_we=0, grant=0, oob_cnt=0 immediately without waiting for a clock edge; after release, req=4'b1000 → grant[3], with the pointer starting at 0.
- With FB_WRITE_ARB_STRICT0_EN defined: req=4'b0111 continuous → grants 0,0,0…; drop req[0] → grants alternate 1,2,1,2.
